// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Shares the single register-file write port (we3/A3/WD3) between two
//   requesters. The in-order pipeline writeback stage (P) always wins. The
//   long-latency execution unit (M) is served through a valid/ready handshake
//   whenever P is not writing.
//
//   The block also keeps a 32-entry scoreboard of destinations that have an
//   M operation in flight. The hazard unit queries it through two lookups.
//
//   A starvation counter limits how long M can be refused. When the limit is
//   reached, wb_stall asks the pipeline for a writeback bubble.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   p_we, p_rd, p_wd        pipeline writeback request
//   m_valid, m_rd, m_wd     M result presented by the execution unit
//   m_ready                 M result accepted this cycle
//   m_issue, m_issue_rd     M operation issued (marks the destination busy)
//   rs1, rs2                hazard lookup addresses
//   busy_rs1, busy_rs2      lookup results (registered state only)
//   wb_stall                pipeline must hold p_we low this cycle
//   sb_conflict             one-cycle pulse: issue to an already-busy register
//   rf_we, rf_a3, rf_wd     register-file write port
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    localparam int CW = $clog2(STARVE_LIMIT + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p_we,
    input  logic [4:0]  p_rd,
    input  logic [31:0] p_wd,
    input  logic        m_valid,
    input  logic [4:0]  m_rd,
    input  logic [31:0] m_wd,
    output logic        m_ready,
    input  logic        m_issue,
    input  logic [4:0]  m_issue_rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        busy_rs1,
    output logic        busy_rs2,
    output logic        wb_stall,
    output logic        sb_conflict,
    output logic        rf_we,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd
);

    localparam logic [CW-1:0] LIMIT_CNT = CW'(STARVE_LIMIT);

    logic          p_act;
    logic          p_grant;
    logic          m_fire;
    logic          m_write;
    logic [31:0]   busy;
    logic [31:0]   busy_next;
    logic          conflict_next;
    logic [CW-1:0] starve_cnt;

    // A write to x0 is not a request, so it never blocks M.
    assign p_act   = p_we & (p_rd != 5'd0);

    // p_grant is gated by rst_n so that the port stays quiet during reset.
    assign p_grant = rst_n & p_act;

    // m_ready does not look at m_valid. M can therefore see the grant
    // without a combinational loop through its own valid.
    assign m_ready = rst_n & ~p_act;
    assign m_fire  = m_valid & m_ready;

    // An M result to x0 completes the handshake but is not written.
    assign m_write = m_fire & (m_rd != 5'd0);

    // The write port is purely combinational. The register file captures
    // the write on the same edge as an unarbitrated writeback would.
    always_comb begin
        rf_we = 1'b0;
        rf_a3 = 5'd0;
        rf_wd = 32'd0;
        if (p_grant) begin
            rf_we = 1'b1;
            rf_a3 = p_rd;
            rf_wd = p_wd;
        end else if (m_write) begin
            rf_we = 1'b1;
            rf_a3 = m_rd;
            rf_wd = m_wd;
        end
    end

    // Scoreboard next state. The clear is applied first and the set second,
    // so a back-to-back issue to the register being retired stays busy.
    // Bit 0 is forced low so that x0 never reports a hazard.
    always_comb begin
        busy_next = busy;
        if (m_fire) begin
            busy_next[m_rd] = 1'b0;
        end
        if (m_issue && (m_issue_rd != 5'd0)) begin
            busy_next[m_issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // A conflict means the register was already pending and is not retired
    // on this same edge. Re-issuing while the old result retires is the
    // normal back-to-back case and is not reported.
    assign conflict_next = m_issue
                         & (m_issue_rd != 5'd0)
                         & busy[m_issue_rd]
                         & ~(m_fire & (m_rd == m_issue_rd));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 32'd0;
            sb_conflict <= 1'b0;
        end else begin
            busy        <= busy_next;
            sb_conflict <= conflict_next;
        end
    end

    // Lookups read the registered scoreboard only. An issue or retire in the
    // current cycle becomes visible one cycle later.
    assign busy_rs1 = busy[rs1];
    assign busy_rs2 = busy[rs2];

    // Counts the consecutive cycles in which M is refused. The count
    // saturates at the limit, so a pipeline that ignores wb_stall keeps
    // seeing the request instead of wrapping around.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (m_valid && !m_ready) begin
            if (starve_cnt != LIMIT_CNT) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    assign wb_stall = (starve_cnt == LIMIT_CNT);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Directed bench for regfile_wb_arbiter (STARVE_LIMIT = 4).
//
// The stimulus process drives inputs one time unit after each rising edge.
// It pushes the hand-computed expected outputs for that cycle into a queue.
// A monitor process samples the outputs at the following falling edge and
// checks them against the head of the queue.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        p_we;
    logic [4:0]  p_rd;
    logic [31:0] p_wd;
    logic        m_valid;
    logic [4:0]  m_rd;
    logic [31:0] m_wd;
    logic        m_ready;
    logic        m_issue;
    logic [4:0]  m_issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        busy_rs1;
    logic        busy_rs2;
    logic        wb_stall;
    logic        sb_conflict;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        bit          chk_data;
        logic        rf_we;
        logic [4:0]  rf_a3;
        logic [31:0] rf_wd;
        logic        m_ready;
        logic        busy_rs1;
        logic        busy_rs2;
        logic        wb_stall;
        logic        sb_conflict;
    } exp_t;

    exp_t exp_q[$];

    regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .p_we        (p_we),
        .p_rd        (p_rd),
        .p_wd        (p_wd),
        .m_valid     (m_valid),
        .m_rd        (m_rd),
        .m_wd        (m_wd),
        .m_ready     (m_ready),
        .m_issue     (m_issue),
        .m_issue_rd  (m_issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .busy_rs1    (busy_rs1),
        .busy_rs2    (busy_rs2),
        .wb_stall    (wb_stall),
        .sb_conflict (sb_conflict),
        .rf_we       (rf_we),
        .rf_a3       (rf_a3),
        .rf_wd       (rf_wd)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compares one field and logs a line if it differs from the expected value.
    task automatic check_output(input string name, input string field,
                                input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h", name, field, actual, expected);
        end
    endtask

    // Checks every output against the expectation queued for this cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_output(e.name, "rf_we", 32'(rf_we), 32'(e.rf_we));
            if (e.chk_data) begin
                check_output(e.name, "rf_a3", 32'(rf_a3), 32'(e.rf_a3));
                check_output(e.name, "rf_wd", rf_wd, e.rf_wd);
            end
            check_output(e.name, "m_ready", 32'(m_ready), 32'(e.m_ready));
            check_output(e.name, "busy_rs1", 32'(busy_rs1), 32'(e.busy_rs1));
            check_output(e.name, "busy_rs2", 32'(busy_rs2), 32'(e.busy_rs2));
            check_output(e.name, "wb_stall", 32'(wb_stall), 32'(e.wb_stall));
            check_output(e.name, "sb_conflict", 32'(sb_conflict), 32'(e.sb_conflict));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic we, input logic [4:0] prd, input logic [31:0] pwd,
                                  input logic mv, input logic [4:0] mrd, input logic [31:0] mwd,
                                  input logic iss, input logic [4:0] iss_rd,
                                  input logic [4:0] a1, input logic [4:0] a2);
        p_we       = we;
        p_rd       = prd;
        p_wd       = pwd;
        m_valid    = mv;
        m_rd       = mrd;
        m_wd       = mwd;
        m_issue    = iss;
        m_issue_rd = iss_rd;
        rs1        = a1;
        rs2        = a2;
    endtask

    task automatic expect_out(input string name, input bit chk_data,
                              input logic we, input logic [4:0] a3, input logic [31:0] wd,
                              input logic mr, input logic b1, input logic b2,
                              input logic st, input logic cf);
        exp_t e;
        e.name        = name;
        e.chk_data    = chk_data;
        e.rf_we       = we;
        e.rf_a3       = a3;
        e.rf_wd       = wd;
        e.m_ready     = mr;
        e.busy_rs1    = b1;
        e.busy_rs2    = b2;
        e.wb_stall    = st;
        e.sb_conflict = cf;
        exp_q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset with an active pipeline write pending.
        next_cycle();
        apply_stimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0);
        expect_out("rst_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        rst_n = 1'b1;
        apply_stimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0);
        expect_out("rst_release", 1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);

        // Contention: P wins, and M is granted once P goes idle.
        next_cycle();
        apply_stimulus(1, 3, 32'hAAAA0003, 1, 7, 32'h12345678, 0, 0, 0, 0);
        expect_out("cont_p_wins", 1, 1, 3, 32'hAAAA0003, 0, 0, 0, 0, 0);
        next_cycle();
        apply_stimulus(0, 3, 32'hAAAA0003, 1, 7, 32'h12345678, 0, 0, 0, 0);
        expect_out("cont_m_grant", 1, 1, 7, 32'h12345678, 1, 0, 0, 0, 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("cont_idle", 1, 0, 0, 0, 1, 0, 0, 0, 0);

        // Scoreboard: set, clear, then set and clear on the same edge.
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 9, 9, 7);
        expect_out("sb_issue", 1, 0, 0, 0, 1, 0, 0, 0, 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 1, 9, 32'h00000099, 0, 0, 9, 7);
        expect_out("sb_busy_fire", 1, 1, 9, 32'h00000099, 1, 1, 0, 0, 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 7);
        expect_out("sb_cleared", 1, 0, 0, 0, 1, 0, 0, 0, 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 9, 9, 7);
        expect_out("sb_reissue", 1, 0, 0, 0, 1, 0, 0, 0, 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 1, 9, 32'h00000999, 1, 9, 9, 7);
        expect_out("sb_set_clear", 1, 1, 9, 32'h00000999, 1, 1, 0, 0, 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 7);
        expect_out("sb_set_wins", 1, 0, 0, 0, 1, 1, 0, 0, 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 1, 9, 32'h00000009, 0, 0, 9, 7);
        expect_out("sb_drain", 1, 1, 9, 32'h00000009, 1, 1, 0, 0, 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 7);
        expect_out("sb_drained", 1, 0, 0, 0, 1, 0, 0, 0, 0);

        // Starvation: wb_stall rises on the fifth refused cycle.
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            apply_stimulus(1, 1, 32'h11111111, 1, 12, 32'hC0C0C0C0, 0, 0, 12, 0);
            expect_out("starve_wait", 1, 1, 1, 32'h11111111, 0, 0, 0, (i == 4), 0);
        end
        next_cycle();
        apply_stimulus(1, 1, 32'h11111111, 1, 12, 32'hC0C0C0C0, 0, 0, 12, 0);
        expect_out("starve_violate", 1, 1, 1, 32'h11111111, 0, 0, 0, 1, 0);
        next_cycle();
        apply_stimulus(0, 1, 32'h11111111, 1, 12, 32'hC0C0C0C0, 0, 0, 12, 0);
        expect_out("starve_m_wins", 1, 1, 12, 32'hC0C0C0C0, 1, 0, 0, 1, 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 12, 0);
        expect_out("starve_drop", 1, 0, 0, 0, 1, 0, 0, 0, 0);

        // x0 handling for P, for M results and for M issue.
        next_cycle();
        apply_stimulus(1, 0, 32'h00000055, 1, 14, 32'h0000E0E0, 0, 0, 14, 0);
        expect_out("x0_p_nonreq", 1, 1, 14, 32'h0000E0E0, 1, 0, 0, 0, 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 1, 0, 32'h0000FFFF, 0, 0, 14, 0);
        expect_out("x0_m_rd0", 1, 0, 0, 0, 1, 0, 0, 0, 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        expect_out("x0_issue", 1, 0, 0, 0, 1, 0, 0, 0, 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        expect_out("x0_issue2", 1, 0, 0, 0, 1, 0, 0, 0, 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("x0_busy0", 1, 0, 0, 0, 1, 0, 0, 0, 0);

        // Double issue to x4 without a completion: one-cycle conflict pulse.
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 4, 4, 0);
        expect_out("cf_first", 1, 0, 0, 0, 1, 0, 0, 0, 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 4, 4, 0);
        expect_out("cf_second", 1, 0, 0, 0, 1, 1, 0, 0, 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
        expect_out("cf_pulse", 1, 0, 0, 0, 1, 1, 0, 0, 1);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
        expect_out("cf_pulse_end", 1, 0, 0, 0, 1, 1, 0, 0, 0);

        // Saturate the starvation counter, then reset mid-cycle.
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            apply_stimulus(1, 2, 32'h22222222, 1, 15, 32'hF0F0F0F0, 0, 0, 4, 0);
            expect_out("rst_prep", 1, 1, 2, 32'h22222222, 0, 1, 0, (i == 4), 0);
        end
        next_cycle();
        rst_n = 1'b0;
        apply_stimulus(1, 2, 32'h22222222, 1, 15, 32'hF0F0F0F0, 0, 0, 4, 0);
        expect_out("async_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        rst_n = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
        expect_out("post_rst", 1, 0, 0, 0, 1, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        check_output("end", "queue_left", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Arbitrates the single register-file write port (we3/A3/WD3) between two requesters:
  - the in-order pipeline writeback stage (P);
  - a long-latency execution unit (M, e.g. mul/div), which uses a valid/ready handshake.
- Holds a 32-entry scoreboard of destinations with an M operation in flight. The hazard unit queries it through two read-port lookups.
- Prevents M starvation by requesting a pipeline writeback bubble after a bounded wait.
- Sits between the writeback stage, the M unit, the hazard unit and RegisterFile.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles M may be refused before wb_stall asserts. Legal range 1..255.
- CW, $clog2(STARVE_LIMIT+1): starvation counter width. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- p_we  in  1  pipeline writeback write enable
- p_rd  in  5  pipeline destination register
- p_wd  in  32  pipeline write data
- m_valid  in  1  M result valid
- m_rd  in  5  M destination register
- m_wd  in  32  M result data
- m_ready  out  1  M result accepted this cycle
- m_issue  in  1  M operation issued this cycle (sets scoreboard)
- m_issue_rd  in  5  destination of the issued M operation
- rs1  in  5  hazard lookup address 1
- rs2  in  5  hazard lookup address 2
- busy_rs1  out  1  rs1 has an M write pending
- busy_rs2  out  1  rs2 has an M write pending
- wb_stall  out  1  request: pipeline must hold p_we low this cycle
- sb_conflict  out  1  registered one-cycle pulse: issue to an already-busy register
- rf_we  out  1  to RegisterFile we3
- rf_a3  out  5  to RegisterFile A3
- rf_wd  out  32  to RegisterFile WD3

Behaviour:
- Port path is combinational, with zero added latency. The write lands at the same clk edge as an unarbitrated writeback would.
- p_act = p_we & (p_rd != 0). A P write to x0 is a non-request and does not occupy the port.
- Priority:
  - P always wins when p_act.
  - m_ready = rst_n & ~p_act. m_ready does not depend on m_valid.
- m_fire = m_valid & m_ready. Once m_valid is asserted, M must hold m_valid/m_rd/m_wd stable until m_fire.
- Port drive:
  - If p_act: rf_we=1, rf_a3=p_rd, rf_wd=p_wd.
  - Else if m_fire and m_rd != 0: rf_we=1, rf_a3=m_rd, rf_wd=m_wd.
  - Else: rf_we=0, rf_a3=0, rf_wd=0.
- An M result to x0 is accepted (m_ready handshake completes) but not written.
- While rst_n=0: rf_we=0 and m_ready=0, regardless of inputs.
- Scoreboard busy[31:0], registered, reset 0:
  - On m_issue with m_issue_rd != 0: set busy[m_issue_rd].
  - On m_fire: clear busy[m_rd].
  - Same register set and cleared in one cycle: the set wins (back-to-back M ops to the same rd).
  - busy[0] is constant 0.
- busy_rs1 = busy[rs1] and busy_rs2 = busy[rs2]. Both read registered state only; there is no same-cycle bypass of m_issue or m_fire.
- sb_conflict asserts for one cycle following an edge where m_issue, m_issue_rd != 0, busy[m_issue_rd]=1 and no same-cycle clear of that register occurred. Reset value 0.
- Starvation counter starve_cnt, CW bits, reset 0:
  - If m_valid & ~m_ready: increment, saturating at STARVE_LIMIT.
  - Otherwise (m_fire, or m_valid=0): cleared to 0.
- wb_stall = (starve_cnt == STARVE_LIMIT), decoded from the register. Reset value 0.
- Contract: the pipeline drives p_we=0 in every cycle wb_stall=1, so M wins that cycle, starve_cnt returns to 0 and wb_stall drops the next cycle.
- If the pipeline violates the contract, P still wins, starve_cnt stays saturated and wb_stall stays high. There is no data loss.
- Reset mid-operation (asynchronous):
  - busy, starve_cnt and sb_conflict clear immediately.
  - Any M result in flight is refused. M is responsible for re-presenting it after reset.
- Worst-case M wait after m_valid rises: STARVE_LIMIT+1 cycles.

Test Plan:
- Reset, no traffic: p_we=1, p_rd=5, p_wd=0xDEADBEEF with rst_n=0 -> rf_we=0, m_ready=0, all busy=0. After release, the same inputs give rf_we=1, rf_a3=5, rf_wd=0xDEADBEEF.
- Contention: p_we=1, p_rd=3 and m_valid=1, m_rd=7, m_wd=0x12345678 -> P written, m_ready=0. Next cycle p_we=0 -> rf_a3=7, rf_wd=0x12345678, m_ready=1.
- Scoreboard: m_issue, m_issue_rd=9 -> next cycle busy_rs1=1 for rs1=9. m_fire with m_rd=9 -> busy clears the following cycle. Issue rd=9 on the same edge as the clear -> busy stays 1 and sb_conflict stays 0.
- Starvation with STARVE_LIMIT=4: m_valid held high with p_we=1, p_rd=1 every cycle -> wb_stall=1 on the 5th cycle. Pipeline drops p_we -> M written, wb_stall=0 the next cycle.
- x0 handling: p_we=1, p_rd=0 with M pending -> M granted. m_rd=0 -> m_ready=1, rf_we=0, no busy change. m_issue_rd=0 -> busy stays all 0.
- Conflict and async reset: issue rd=4 twice without a completion -> sb_conflict pulses one cycle. Assert rst_n=0 mid-cycle -> busy[4] and starve_cnt clear before the next clk edge.
